// File: rtl/rpn_pkg.sv
// rpn_pkg: opcodes, error codes and FSM states shared by the RPN stack controller.
package rpn_pkg;
    localparam logic [2:0] OP_SOMA  = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MULTI = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_NOT   = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_DIV0 = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
endpackage

// File: rtl/rpn_pilha.sv
// rpn_pilha: operand stack register file with push, pop-two-push-one, replace-top, clear and depth count.
module rpn_pilha #(
    parameter int PROFUNDIDADE = 4,
    localparam int DW = $clog2(PROFUNDIDADE + 1),
    localparam int AW = $clog2(PROFUNDIDADE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop2,
    input  logic          i_repl,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_top,
    output logic [7:0]    o_second,
    output logic [DW-1:0] o_depth,
    output logic          o_full
);
    localparam logic [DW-1:0] FULL = DW'(PROFUNDIDADE);

    logic [7:0]    r_mem [PROFUNDIDADE];
    logic [DW-1:0] r_depth;
    logic [AW-1:0] w_ipush, w_itop, w_isec;

    // Entry 0 is the bottom; the top lives at index depth-1.
    assign w_ipush  = AW'(r_depth);
    assign w_itop   = AW'(r_depth - 1'b1);
    assign w_isec   = AW'(r_depth - 2'd2);
    assign o_full   = (r_depth == FULL);
    assign o_depth  = r_depth;
    assign o_top    = (r_depth == '0) ? 8'h00 : r_mem[w_itop];
    assign o_second = |r_depth[DW-1:1] ? r_mem[w_isec] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_depth <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++) r_mem[i] <= 8'h00;
        end else if (i_push) begin
            if (!o_full) begin
                r_mem[w_ipush] <= i_data;
                r_depth        <= r_depth + 1'b1;
            end
        end else if (i_pop2) begin
            r_mem[w_isec] <= i_wdata;
            r_depth       <= r_depth - 1'b1;
        end else if (i_repl) begin
            r_mem[w_itop] <= i_wdata;
        end
    end
endmodule

// File: rtl/rpn_controlador.sv
// rpn_controlador: RPN stack controller issuing Sel/OperA/OperB to the ALU and writing Result back.
// Define RPN_DIV_ZERO_CHECK_EN to reject Div with a zero top entry (error 11).
module rpn_controlador
    import rpn_pkg::*;
#(
    parameter int PROFUNDIDADE = 4
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              Limpar,
    input  logic                              Push,
    input  logic [7:0]                        Entrada,
    input  logic                              OpValid,
    input  logic [2:0]                        OpCode,
    input  logic [7:0]                        Result,
    output logic [2:0]                        Sel,
    output logic [7:0]                        OperA,
    output logic [7:0]                        OperB,
    output logic [7:0]                        Topo,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] Profundidade,
    output logic                              Busy,
    output logic [1:0]                        ErroCod
);
    localparam int DW = $clog2(PROFUNDIDADE + 1);

    state_t     r_state;
    logic [2:0] r_sel;
    logic [7:0] r_opa, r_opb;
    logic [1:0] r_err;
    logic [7:0] w_top, w_sec;
    logic       w_full, w_idle, w_is_not, w_enough, w_div0;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_is_not = (OpCode == OP_NOT);
    assign w_enough = w_is_not ? |Profundidade : |Profundidade[DW-1:1];
`ifdef RPN_DIV_ZERO_CHECK_EN
    assign w_div0   = (OpCode == OP_DIV) && (w_top == 8'h00);
`else
    assign w_div0   = 1'b0;
`endif

    rpn_pilha #(.PROFUNDIDADE(PROFUNDIDADE)) u_pilha (
        .i_clk    (Clk),
        .i_rst    (Rst),
        .i_clear  (Limpar),
        .i_push   (w_idle && Push),
        .i_data   (Entrada),
        .i_pop2   (r_state == ST_EXEC && r_sel != OP_NOT),
        .i_repl   (r_state == ST_EXEC && r_sel == OP_NOT),
        .i_wdata  (Result),
        .o_top    (w_top),
        .o_second (w_sec),
        .o_depth  (Profundidade),
        .o_full   (w_full)
    );

    // The stack is written on the EXEC edge so the result shows during WB.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_sel   <= OP_SOMA;
            r_opa   <= 8'h00;
            r_opb   <= 8'h00;
            r_err   <= ERR_NONE;
        end else if (Limpar) begin
            r_state <= ST_IDLE;
            r_err   <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Push) begin
                        if (w_full && r_err == ERR_NONE) r_err <= ERR_OVF;
                    end else if (OpValid) begin
                        if (!w_enough) begin
                            if (r_err == ERR_NONE) r_err <= ERR_UNF;
                        end else if (w_div0) begin
                            if (r_err == ERR_NONE) r_err <= ERR_DIV0;
                        end else begin
                            r_state <= ST_EXEC;
                            r_sel   <= OpCode;
                            r_opa   <= w_is_not ? w_top : w_sec;
                            r_opb   <= w_is_not ? 8'h00 : w_top;
                        end
                    end
                end
                ST_EXEC: r_state <= ST_WB;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Sel     = r_sel;
    assign OperA   = r_opa;
    assign OperB   = r_opb;
    assign Topo    = w_top;
    assign Busy    = !w_idle;
    assign ErroCod = r_err;
endmodule

// File: tb/tb_rpn_controlador.sv
// tb_rpn_controlador: directed self-checking bench for rpn_controlador (PROFUNDIDADE=4).
module tb_rpn_controlador;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0, Limpar = 1'b0, Push = 1'b0, OpValid = 1'b0;
    logic [7:0] Entrada = 8'h00, Result = 8'h00;
    logic [2:0] OpCode = 3'd0;
    logic [2:0] Sel;
    logic [7:0] OperA, OperB, Topo;
    logic [2:0] Profundidade;
    logic       Busy;
    logic [1:0] ErroCod;
    int n_checks = 0;
    int n_fail = 0;

    rpn_controlador #(.PROFUNDIDADE(4)) dut (
        .Clk(Clk), .Rst(Rst), .Limpar(Limpar), .Push(Push), .Entrada(Entrada),
        .OpValid(OpValid), .OpCode(OpCode), .Result(Result), .Sel(Sel),
        .OperA(OperA), .OperB(OperB), .Topo(Topo), .Profundidade(Profundidade),
        .Busy(Busy), .ErroCod(ErroCod)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        Push = 1'b1;
        Entrada = v;
        step();
        Push = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op);
        OpValid = 1'b1;
        OpCode = op;
        step();
        OpValid = 1'b0;
    endtask

    task automatic test_reset();
        Push = 1'b1; Entrada = 8'hAA; step(); Push = 1'b0;
        do_reset();
        n_checks++; if ({Sel, OperA, OperB} !== 19'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h want 0 0 0", Sel, OperA, OperB); end
        n_checks++; if (Topo !== 8'h00) begin n_fail++; $display("FAIL reset_topo: got %h want 00", Topo); end
        n_checks++; if (Profundidade !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", Profundidade); end
        n_checks++; if ({Busy, ErroCod} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_err: got %b %b want 0 00", Busy, ErroCod); end
    endtask

    task automatic test_sub();
        do_reset();
        push(8'd9);
        push(8'd4);
        issue(3'd1);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL sub_exec_busy: got %b want 1", Busy); end
        n_checks++; if (Sel !== 3'b001) begin n_fail++; $display("FAIL sub_sel: got %b want 001", Sel); end
        n_checks++; if (OperA !== 8'd9 || OperB !== 8'd4) begin n_fail++; $display("FAIL sub_opers: got %0d %0d want 9 4", OperA, OperB); end
        Result = 8'd5;
        step();
        n_checks++; if (Topo !== 8'd5 || Profundidade !== 3'd1) begin n_fail++; $display("FAIL sub_wb: got topo %0d depth %0d want 5 1", Topo, Profundidade); end
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL sub_wb_busy: got %b want 1", Busy); end
        step();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL sub_idle_busy: got %b want 0", Busy); end
        n_checks++; if (Topo !== 8'd5 || Profundidade !== 3'd1) begin n_fail++; $display("FAIL sub_after: got topo %0d depth %0d want 5 1", Topo, Profundidade); end
        n_checks++; if (Sel !== 3'b001 || OperA !== 8'd9) begin n_fail++; $display("FAIL sub_hold: got sel %b A %0d want 001 9", Sel, OperA); end
    endtask

    task automatic test_not();
        do_reset();
        push(8'h0F);
        issue(3'd7);
        n_checks++; if (Sel !== 3'b111 || OperA !== 8'h0F || OperB !== 8'h00) begin n_fail++; $display("FAIL not_exec: got %b %h %h want 111 0f 00", Sel, OperA, OperB); end
        Result = 8'hF0;
        step();
        step();
        n_checks++; if (Topo !== 8'hF0 || Profundidade !== 3'd1 || Busy !== 1'b0) begin n_fail++; $display("FAIL not_wb: got %h %0d %b want f0 1 0", Topo, Profundidade, Busy); end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(3'd0);
        n_checks++; if (ErroCod !== 2'b10 || Busy !== 1'b0) begin n_fail++; $display("FAIL unf_err: got %b busy %b want 10 0", ErroCod, Busy); end
        step();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL unf_busy: got %b want 0", Busy); end
        push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(8'd5);
        n_checks++; if (ErroCod !== 2'b10 || Profundidade !== 3'd4) begin n_fail++; $display("FAIL unf_latch_first: got %b depth %0d want 10 4", ErroCod, Profundidade); end
        Limpar = 1'b1; step(); Limpar = 1'b0;
        n_checks++; if (ErroCod !== 2'b00 || Profundidade !== 3'd0 || Topo !== 8'h00) begin n_fail++; $display("FAIL unf_limpar: got %b %0d %h want 00 0 00", ErroCod, Profundidade, Topo); end
    endtask

    task automatic test_overflow();
        do_reset();
        push(8'd1); push(8'd2); push(8'd3); push(8'd4);
        n_checks++; if (ErroCod !== 2'b00 || Profundidade !== 3'd4) begin n_fail++; $display("FAIL ovf_full: got %b %0d want 00 4", ErroCod, Profundidade); end
        push(8'd5);
        n_checks++; if (ErroCod !== 2'b01 || Topo !== 8'd4 || Profundidade !== 3'd4) begin n_fail++; $display("FAIL ovf: got %b %0d %0d want 01 4 4", ErroCod, Topo, Profundidade); end
    endtask

    task automatic test_div();
        do_reset();
        push(8'd8);
        push(8'd0);
        issue(3'd3);
`ifdef RPN_DIV_ZERO_CHECK_EN
        n_checks++; if (ErroCod !== 2'b11 || Profundidade !== 3'd2 || Topo !== 8'h00 || Busy !== 1'b0) begin n_fail++; $display("FAIL div0_reject: got %b %0d %h %b want 11 2 00 0", ErroCod, Profundidade, Topo, Busy); end
`else
        n_checks++; if (Busy !== 1'b1 || Sel !== 3'b011 || OperA !== 8'd8 || OperB !== 8'd0) begin n_fail++; $display("FAIL div_exec: got %b %b %0d %0d want 1 011 8 0", Busy, Sel, OperA, OperB); end
        Result = 8'hFF;
        step();
        step();
        n_checks++; if (Topo !== 8'hFF || Profundidade !== 3'd1 || ErroCod !== 2'b00) begin n_fail++; $display("FAIL div_wb: got %h %0d %b want ff 1 00", Topo, Profundidade, ErroCod); end
`endif
    endtask

    task automatic test_limpar_exec();
        do_reset();
        push(8'd2);
        push(8'd3);
        issue(3'd0);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL clr_exec_busy: got %b want 1", Busy); end
        Result = 8'd5;
        Limpar = 1'b1; step(); Limpar = 1'b0;
        n_checks++; if (Profundidade !== 3'd0 || Busy !== 1'b0 || Topo !== 8'h00) begin n_fail++; $display("FAIL clr_exec: got %0d %b %h want 0 0 00", Profundidade, Busy, Topo); end
        step();
        n_checks++; if (Profundidade !== 3'd0 || Busy !== 1'b0) begin n_fail++; $display("FAIL clr_no_wb: got %0d %b want 0 0", Profundidade, Busy); end
    endtask

    task automatic test_push_and_op();
        do_reset();
        push(8'd6);
        push(8'd1);
        Push = 1'b1; Entrada = 8'd7; OpValid = 1'b1; OpCode = 3'd0;
        step();
        Push = 1'b0; OpValid = 1'b0;
        n_checks++; if (Busy !== 1'b0 || Profundidade !== 3'd3 || Topo !== 8'd7) begin n_fail++; $display("FAIL push_op: got %b %0d %0d want 0 3 7", Busy, Profundidade, Topo); end
        step();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL push_op_idle: got %b want 0", Busy); end
    endtask

    task automatic test_ignore_busy();
        do_reset();
        push(8'd10);
        push(8'd3);
        issue(3'd4);
        Result = 8'd2;
        Push = 1'b1; Entrada = 8'd99; OpValid = 1'b1;
        step();
        step();
        Push = 1'b0; OpValid = 1'b0;
        n_checks++; if (Busy !== 1'b0 || Topo !== 8'd2 || Profundidade !== 3'd1) begin n_fail++; $display("FAIL busy_ignore: got %b %0d %0d want 0 2 1", Busy, Topo, Profundidade); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_not();
        test_underflow();
        test_overflow();
        test_div();
        test_limpar_exec();
        test_push_and_op();
        test_ignore_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
